warp_dispatch_queue: RTL and testbench

//  Parametrised warp dispatcher between the warp scheduler and NUM_CORES SIMD cores.

---
 rtl/warp_dispatch_queue.sv | 176 +++++++++++++++++
 tb/tb_warp_dispatch_queue.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_dispatch_queue.sv
// Warp dispatcher: buffers scheduler warps in a FIFO, launches them onto free SIMD cores
// (round-robin or lowest-index), tracks core busy state and serialises completion reports.
module warp_dispatch_queue #(
  parameter int NUM_CORES   = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int WARP_ID_W   = 4,
  parameter int THREAD_W    = 5,
  parameter int PC_W        = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic [WARP_ID_W-1:0]             i_in_warp_id,
  input  logic [PC_W-1:0]                  i_in_pc,
  input  logic [THREAD_W-1:0]              i_in_num_threads,
  input  logic                             i_policy_rr,
  input  logic                             i_flush,
  output logic [NUM_CORES-1:0]             o_core_launch,
  output logic [WARP_ID_W-1:0]             o_core_warp_id,
  output logic [PC_W-1:0]                  o_core_pc,
  output logic [THREAD_W-1:0]              o_core_num_threads,
  input  logic [NUM_CORES-1:0]             i_core_done,
  output logic [NUM_CORES-1:0]             o_core_busy,
  output logic                             o_done_valid,
  output logic [WARP_ID_W-1:0]             o_done_warp_id,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_queue_count,
  output logic                             o_err_spurious
);

  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                 r_live;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [WARP_ID_W-1:0] r_fifo_id  [QUEUE_DEPTH];
  logic [PC_W-1:0]      r_fifo_pc  [QUEUE_DEPTH];
  logic [THREAD_W-1:0]  r_fifo_thr [QUEUE_DEPTH];

  logic [NUM_CORES-1:0] r_busy;
  logic [NUM_CORES-1:0] r_pending;
  logic [NUM_CORES-1:0] r_launch;
  logic [WARP_ID_W-1:0] r_core_id [NUM_CORES];
  logic [WARP_ID_W-1:0] r_pend_id [NUM_CORES];
  logic [CORE_W-1:0]    r_rr_ptr;
  logic [WARP_ID_W-1:0] r_out_id;
  logic [PC_W-1:0]      r_out_pc;
  logic [THREAD_W-1:0]  r_out_thr;
  logic                 r_err;

  logic                 w_push;
  logic                 w_pop;
  logic [NUM_CORES-1:0] w_free;
  logic [NUM_CORES-1:0] w_fin;
  logic [CORE_W-1:0]    w_grant_idx;
  logic [NUM_CORES-1:0] w_grant_oh;
  logic [NUM_CORES-1:0] w_launch_oh;
  logic [NUM_CORES-1:0] w_rep_oh;
  logic [WARP_ID_W-1:0] w_done_id;

  // First free core at or after 'base', wrapping; caller guarantees at least one is free.
  function automatic logic [CORE_W-1:0] f_pick(input logic [NUM_CORES-1:0] free, input int base);
    logic [CORE_W-1:0]    sel;
    logic                 hit;
    logic [NUM_CORES-1:0] sh;
    int                   idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = base + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      sh = free >> idx;
      if (!hit && sh[0]) begin
        hit = 1'b1;
        sel = CORE_W'(idx);
      end
    end
    return sel;
  endfunction

  assign o_in_ready  = r_live & (r_count < CNT_W'(QUEUE_DEPTH));
  assign w_push      = i_in_valid & o_in_ready & ~i_flush;
  assign w_free      = ~r_busy;
  assign w_pop       = (r_count != '0) & (|w_free) & ~i_flush;
  assign w_grant_idx = f_pick(w_free, i_policy_rr ? int'(r_rr_ptr) : 0);
  assign w_grant_oh  = NUM_CORES'(1) << w_grant_idx;
  assign w_launch_oh = w_pop ? w_grant_oh : '0;
  assign w_fin       = i_core_done & r_busy;
  // Lowest set pending bit is the one reported this cycle.
  assign w_rep_oh    = r_pending & (~r_pending + NUM_CORES'(1));

  always_comb begin
    w_done_id = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_rep_oh[i]) w_done_id = w_done_id | r_pend_id[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]  <= i_in_warp_id;
      r_fifo_pc[r_wr_ptr]  <= i_in_pc;
      r_fifo_thr[r_wr_ptr] <= i_in_num_threads;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live    <= 1'b0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_busy    <= '0;
      r_pending <= '0;
      r_launch  <= '0;
      r_rr_ptr  <= '0;
      r_out_id  <= '0;
      r_out_pc  <= '0;
      r_out_thr <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_core_id[i] <= '0;
        r_pend_id[i] <= '0;
      end
    end else begin
      r_live <= 1'b1;
      if (i_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end

      r_launch <= w_launch_oh;
      if (w_pop) begin
        r_out_id  <= r_fifo_id[r_rd_ptr];
        r_out_pc  <= r_fifo_pc[r_rd_ptr];
        r_out_thr <= r_fifo_thr[r_rd_ptr];
        if (i_policy_rr) begin
          r_rr_ptr <= (w_grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : w_grant_idx + CORE_W'(1);
        end
      end

      r_busy    <= (r_busy & ~w_fin) | w_launch_oh;
      r_pending <= (r_pending & ~w_rep_oh) | w_fin;
      // Report id is captured at completion so a quick relaunch cannot overwrite it.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_launch_oh[i]) r_core_id[i] <= r_fifo_id[r_rd_ptr];
        if (w_fin[i])       r_pend_id[i] <= r_core_id[i];
      end

      if (|(i_core_done & ~r_busy)) r_err <= 1'b1;
    end
  end

  assign o_core_launch      = r_launch;
  assign o_core_warp_id     = r_out_id;
  assign o_core_pc          = r_out_pc;
  assign o_core_num_threads = r_out_thr;
  assign o_core_busy        = r_busy;
  assign o_done_valid       = |r_pending;
  assign o_done_warp_id     = w_done_id;
  assign o_queue_count      = r_count;
  assign o_err_spurious     = r_err;

endmodule

// File: tb/tb_warp_dispatch_queue.sv
// Scoreboard bench for warp_dispatch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_warp_dispatch_queue;

  localparam int NC = 4;
  localparam int QD = 8;

  typedef struct {
    int         cyc;
    logic [3:0] oh;
    logic [3:0] id;
    logic [31:0] pc;
    logic [4:0] thr;
  } launch_t;

  typedef struct {
    int         cyc;
    logic [3:0] id;
  } report_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_warp_id = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_num_threads = '0;
  logic        policy_rr = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  core_launch;
  logic [3:0]  core_warp_id;
  logic [31:0] core_pc;
  logic [4:0]  core_num_threads;
  logic [3:0]  core_done = '0;
  logic [3:0]  core_busy;
  logic        done_valid;
  logic [3:0]  done_warp_id;
  logic [3:0]  queue_count;
  logic        err_spurious;

  always #5 clk = ~clk;

  warp_dispatch_queue dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_in_valid         (in_valid),
    .o_in_ready         (in_ready),
    .i_in_warp_id       (in_warp_id),
    .i_in_pc            (in_pc),
    .i_in_num_threads   (in_num_threads),
    .i_policy_rr        (policy_rr),
    .i_flush            (flush),
    .o_core_launch      (core_launch),
    .o_core_warp_id     (core_warp_id),
    .o_core_pc          (core_pc),
    .o_core_num_threads (core_num_threads),
    .i_core_done        (core_done),
    .o_core_busy        (core_busy),
    .o_done_valid       (done_valid),
    .o_done_warp_id     (done_warp_id),
    .o_queue_count      (queue_count),
    .o_err_spurious     (err_spurious)
  );

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  launch_t    m_q[$];
  launch_t    exp_l[$];
  report_t    exp_r[$];
  logic [3:0] m_busy, m_pend;
  logic [3:0] m_id [NC];
  logic [3:0] m_pend_id [NC];
  int         m_rr;
  bit         m_live, m_err;
  logic [3:0] m_last_id;
  logic [31:0] m_last_pc;
  logic [4:0] m_last_thr;
  int         seen[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    exp_l.delete();
    exp_r.delete();
    m_busy = '0;
    m_pend = '0;
    m_rr = 0;
    m_live = 0;
    m_err = 0;
    m_last_id = '0;
    m_last_pc = '0;
    m_last_thr = '0;
    for (int i = 0; i < NC; i++) begin
      m_id[i] = '0;
      m_pend_id[i] = '0;
    end
  endtask

  // Applies one clock edge's worth of behaviour to the model using the inputs seen at that edge.
  task automatic model_step();
    logic [3:0] fin;
    bit         ready;
    bit         got;
    int         c;
    launch_t    w;
    report_t    r;
    if (!rst_n) begin
      model_clear();
      return;
    end
    ready = m_live && (m_q.size() < QD);
    fin = core_done & m_busy;
    if ((core_done & ~m_busy) != 4'b0) m_err = 1;
    got = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_pend[i] && !got) begin
        m_pend[i] = 1'b0;
        got = 1;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (fin[i]) begin
        m_pend[i] = 1'b1;
        m_pend_id[i] = m_id[i];
      end
    end
    c = -1;
    if (!flush && m_q.size() > 0) begin
      for (int k = 0; k < NC; k++) begin
        int j;
        j = policy_rr ? (m_rr + k) % NC : k;
        if (c < 0 && !m_busy[j]) c = j;
      end
    end
    m_busy = m_busy & ~fin;
    if (c >= 0) begin
      w = m_q.pop_front();
      w.cyc = cyc;
      w.oh = 4'b0001 << c;
      m_busy[c] = 1'b1;
      m_id[c] = w.id;
      if (policy_rr) m_rr = (c + 1) % NC;
      m_last_id = w.id;
      m_last_pc = w.pc;
      m_last_thr = w.thr;
      exp_l.push_back(w);
    end
    if (flush) m_q.delete();
    else if (in_valid && ready) begin
      w = '{cyc: 0, oh: 4'b0, id: in_warp_id, pc: in_pc, thr: in_num_threads};
      m_q.push_back(w);
    end
    m_live = 1;
    got = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_pend[i] && !got) begin
        r.cyc = cyc;
        r.id = m_pend_id[i];
        exp_r.push_back(r);
        got = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    if (core_launch != 4'b0) begin
      for (int i = 0; i < NC; i++) if (core_launch[i]) seen.push_back(i);
    end
  endtask

  task automatic set_warp(input bit v, input int id, input logic [31:0] pc, input int thr);
    in_valid = v;
    in_warp_id = 4'(id);
    in_pc = pc;
    in_num_threads = 5'(thr);
  endtask

  task automatic idle_inputs();
    set_warp(0, 0, 32'h0, 0);
    flush = 0;
    core_done = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    for (int n = 0; n < 5; n++) begin
      set_warp($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 31));
      flush = 1'($urandom_range(0, 1));
      policy_rr = 1'($urandom_range(0, 1));
      core_done = 4'($urandom_range(0, 15));
      tick();
      check("reset_outputs_zero",
            {in_ready, core_launch, core_busy, done_valid, queue_count, err_spurious,
             core_warp_id, core_pc, core_num_threads, done_warp_id}, 64'h0);
    end
    idle_inputs();
    policy_rr = 1;
    rst_n = 1;
    #1;
    check("in_ready_before_first_edge", in_ready, 0);
    tick();
    check("in_ready_after_first_edge", in_ready, 1);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      core_done = m_busy;
      tick();
    end
    core_done = '0;
  endtask

  // Monitor: compares DUT outputs against model state and pops expected events.
  always @(negedge clk) begin
    launch_t e;
    report_t r;
    check("queue_count", queue_count, m_q.size());
    check("in_ready", in_ready, (m_live && m_q.size() < QD) ? 1 : 0);
    check("core_busy", core_busy, m_busy);
    check("err_spurious", err_spurious, m_err);
    check("core_fields", {core_warp_id, core_pc, core_num_threads}, {m_last_id, m_last_pc, m_last_thr});
    while (exp_l.size() > 0 && exp_l[0].cyc < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL launch_missed: expected core mask %0h at cycle %0d, not observed", exp_l[0].oh, exp_l[0].cyc);
      void'(exp_l.pop_front());
    end
    if (core_launch != 4'b0 || (exp_l.size() > 0 && exp_l[0].cyc == cyc)) begin
      if (exp_l.size() == 0 || exp_l[0].cyc != cyc) e = '{default: 0};
      else e = exp_l.pop_front();
      check("launch", {core_launch, core_warp_id, core_pc, core_num_threads}, {e.oh, e.id, e.pc, e.thr});
    end
    while (exp_r.size() > 0 && exp_r[0].cyc < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL report_missed: expected id %0h at cycle %0d, not observed", exp_r[0].id, exp_r[0].cyc);
      void'(exp_r.pop_front());
    end
    if (done_valid || (exp_r.size() > 0 && exp_r[0].cyc == cyc)) begin
      if (exp_r.size() == 0 || exp_r[0].cyc != cyc) begin
        check("report_unexpected", {done_valid, done_warp_id}, 5'h0);
      end else begin
        r = exp_r.pop_front();
        check("report", {done_valid, done_warp_id}, {1'b1, r.id});
      end
    end
  end

  int ids[NC] = '{0, 0, 0, 0};
  int wid;

  initial begin
    model_clear();
    do_reset();

    // Single warp on idle cores
    set_warp(1, 3, 32'h100, 16);
    tick();
    idle_inputs();
    tick();
    check("single_launch", core_launch, 4'b0001);
    check("single_busy", core_busy, 4'b0001);
    check("single_id", {core_warp_id, core_pc, core_num_threads}, {4'd3, 32'h100, 5'd16});
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    check("single_report", {done_valid, done_warp_id}, {1'b1, 4'd3});
    tick();
    check("single_report_once", done_valid, 0);

    // Round-robin vs fixed priority with instantly completing cores
    for (int pol = 1; pol >= 0; pol--) begin
      do_reset();
      policy_rr = 1'(pol);
      seen.delete();
      for (int w = 0; w < 8; w++) begin
        set_warp(1, w, 32'h1000 + 32'(w), w + 1);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
          core_done = m_busy;
          tick();
        end
        core_done = '0;
      end
      check("rr_launch_count", seen.size(), 8);
      for (int w = 0; w < 8 && w < seen.size(); w++) begin
        check(pol ? "rr_core_order" : "prio_core_order", seen[w], pol ? (w % NC) : 0);
      end
    end

    // Full FIFO and backpressure
    do_reset();
    wid = 0;
    for (int k = 0; k < 40 && in_ready; k++) begin
      set_warp(1, wid % 16, 32'h2000 + 32'(wid), wid % 32);
      tick();
      if (in_ready || queue_count == 4'd8) wid++;
    end
    set_warp(1, 15, 32'hdead, 7);
    check("full_count", queue_count, 8);
    check("full_ready", in_ready, 0);
    check("full_busy", core_busy, 4'hf);
    tick();
    tick();
    check("full_held_count", queue_count, 8);
    core_done = 4'b0100;
    tick();
    core_done = '0;
    check("full_no_early_launch", core_launch, 4'b0000);
    tick();
    check("full_launch_core2", core_launch, 4'b0100);
    check("full_count_after_pop", queue_count, 7);
    check("full_ready_after_pop", in_ready, 1);
    tick();
    check("full_refill", queue_count, 8);
    idle_inputs();
    drain(30);

    // Simultaneous completion and spurious done
    do_reset();
    policy_rr = 0;
    ids = '{4, 5, 6, 9};
    for (int k = 0; k < NC; k++) begin
      set_warp(1, ids[k], 32'h300 + 32'(k), k);
      tick();
    end
    idle_inputs();
    tick();
    check("simul_busy", core_busy, 4'hf);
    core_done = 4'b1010;
    tick();
    core_done = '0;
    check("simul_report_first", {done_valid, done_warp_id}, {1'b1, 4'd5});
    tick();
    check("simul_report_second", {done_valid, done_warp_id}, {1'b1, 4'd9});
    tick();
    check("simul_report_end", done_valid, 0);
    check("no_err_yet", err_spurious, 0);
    core_done = 4'b0010;
    tick();
    core_done = '0;
    check("spurious_err", err_spurious, 1);
    check("spurious_no_report", done_valid, 0);
    drain(6);

    // Flush with queued warps and busy cores
    do_reset();
    policy_rr = 0;
    for (int k = 0; k < 9; k++) begin
      set_warp(1, k, 32'h400 + 32'(k), k);
      tick();
    end
    idle_inputs();
    check("flush_pre_count", queue_count, 5);
    check("flush_pre_busy", core_busy, 4'hf);
    core_done = 4'b0011;
    flush = 1;
    set_warp(1, 12, 32'h4ff, 3);
    tick();
    idle_inputs();
    check("flush_count", queue_count, 0);
    check("flush_no_launch", core_launch, 4'b0000);
    check("flush_busy_kept", core_busy, 4'b1100);
    check("flush_report_a", {done_valid, done_warp_id}, {1'b1, 4'd0});
    tick();
    check("flush_report_b", {done_valid, done_warp_id}, {1'b1, 4'd1});
    check("flush_still_empty", {core_launch, queue_count}, 8'h0);
    drain(6);

    // Randomized traffic with one mid-run reset
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) do_reset();
      if (n % 97 == 0) policy_rr = 1'($urandom_range(0, 1));
      set_warp($urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom, $urandom_range(0, 31));
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NC; i++) begin
        if (m_busy[i]) core_done[i] = ($urandom_range(0, 3) == 0);
        else core_done[i] = ($urandom_range(0, 299) == 0);
      end
      tick();
    end
    idle_inputs();
    drain(40);
    tick();
    check("launches_all_seen", exp_l.size(), 0);
    check("reports_all_seen", exp_r.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
